// File: rtl/pcpi_result_serializer.sv
// Buffers PCPI write-back results in a small FIFO and streams each one to the host
// as acknowledged nibbles, least-significant nibble first.
module pcpi_result_serializer #(
    parameter  int DATA_W     = 32,
    parameter  int NIB_W      = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic [DATA_W-1:0] pcpi_rd,
    input  logic              host_ack,
    input  logic              clear_ovf,
    output logic [NIB_W-1:0]  nib_out,
    output logic              nib_valid,
    output logic              last_nib,
    output logic              busy,
    output logic              overflow,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam int NUM_NIB = DATA_W / NIB_W;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHOW,
        S_GAP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic              overflow_q;
    logic              ack_q;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shift;

    logic push_req;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic ack_rise;
    logic at_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A LOAD pop frees a slot in the same cycle, so a write into a full FIFO
    // is only dropped when no pop coincides with it.
    assign push_req = pcpi_ready & pcpi_wr;
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign pop      = (state == S_LOAD);
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    assign ack_rise = host_ack & ~ack_q;
    assign at_last  = (idx == IDX_W'(NUM_NIB - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE: if (level != '0) state_next = S_LOAD;
            S_LOAD: state_next = S_SHOW;
            S_SHOW: if (ack_rise) state_next = at_last ? S_IDLE : S_GAP;
            S_GAP:  state_next = S_SHOW;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: the storage array is not reset; resetting the pointers and level already discards its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pcpi_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
            idx        <= '0;
            shift      <= '0;
        end else begin
            ack_q <= host_ack;

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);

            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // A drop in the same cycle wins over a clear request.
            if (drop)           overflow_q <= 1'b1;
            else if (clear_ovf) overflow_q <= 1'b0;

            if (state == S_LOAD) begin
                shift <= mem[rd_ptr];
                idx   <= '0;
            end else if (state == S_SHOW && ack_rise && !at_last) begin
                shift <= shift >> NIB_W;
                idx   <= idx + IDX_W'(1);
            end
        end
    end

    assign nib_valid  = (state == S_SHOW);
    assign nib_out    = nib_valid ? shift[NIB_W-1:0] : '0;
    assign last_nib   = nib_valid & at_last;
    assign busy       = (state != S_IDLE) || (level != '0);
    assign overflow   = overflow_q;
    assign fifo_level = level;

endmodule

// File: tb/tb_pcpi_result_serializer.sv
// Scoreboard bench: stimulus pushes expected nibbles, a negedge monitor pops and compares.
module tb_pcpi_result_serializer;

    localparam int DATA_W     = 32;
    localparam int NIB_W      = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int NUM_NIB    = DATA_W / NIB_W;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic [DATA_W-1:0] pcpi_rd;
    logic              host_ack;
    logic              clear_ovf;
    logic [NIB_W-1:0]  nib_out;
    logic              nib_valid;
    logic              last_nib;
    logic              busy;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    typedef struct packed {
        logic [NIB_W-1:0] nib;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pcpi_result_serializer #(
        .DATA_W(DATA_W), .NIB_W(NIB_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
        .pcpi_rd(pcpi_rd), .host_ack(host_ack), .clear_ovf(clear_ovf),
        .nib_out(nib_out), .nib_valid(nib_valid), .last_nib(last_nib),
        .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a result becomes NUM_NIB nibbles, nibble e = bits 4e+3:4e.
    task automatic push_result(input logic [DATA_W-1:0] d);
        exp_t x;
        for (int e = 0; e < NUM_NIB; e++) begin
            x.nib  = NIB_W'((d >> (NIB_W * e)) & 32'hF);
            x.last = (e == NUM_NIB - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic capture(input logic [DATA_W-1:0] d);
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = d;
        push_result(d);
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !nib_valid; i++) tick();
        if (!nib_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: nib_valid=%b expected 1", nib_valid);
        end
    endtask

    task automatic ack_pulse();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        tick();
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
            wait_valid();
            ack_pulse();
        end
    endtask

    // Monitor: each new nibble presentation pops one expected entry.
    logic             prev_valid = 1'b0;
    logic [NIB_W-1:0] prev_nib   = '0;
    exp_t             mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (nib_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_nibble: got %h with nothing expected", nib_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("nibble", 32'(nib_out), 32'(mon_e.nib));
                    check("last_nib", 32'(last_nib), 32'(mon_e.last));
                end
            end else if (nib_valid) begin
                check("nib_stable", 32'(nib_out), 32'(prev_nib));
            end else begin
                check("last_nib_idle", 32'(last_nib), 32'd0);
            end
            prev_valid = nib_valid;
            prev_nib   = nib_out;
        end
    end

    logic [DATA_W-1:0] burst [4];
    logic              do_cap;

    initial begin
        rst_n      = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        host_ack   = 1'b0;
        clear_ovf  = 1'b0;
        repeat (3) tick();
        check("rst_nib_valid", 32'(nib_valid), 0);
        check("rst_nib_out", 32'(nib_out), 0);
        check("rst_last_nib", 32'(last_nib), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        rst_n = 1'b1;
        tick();

        // Single result, latency and nibble order.
        capture(32'h89ABCDEF);
        check("lat_n1_level", 32'(fifo_level), 1);
        check("lat_n1_valid", 32'(nib_valid), 0);
        tick();
        check("lat_n2_valid", 32'(nib_valid), 0);
        tick();
        check("lat_n3_valid", 32'(nib_valid), 1);
        check("lat_n3_nib", 32'(nib_out), 32'hF);
        drain();
        check("t1_busy_done", 32'(busy), 0);

        // Held ack advances once; re-arm needs a low then high.
        capture(32'h13579BDF);
        wait_valid();
        host_ack = 1'b1;
        repeat (5) tick();
        check("held_ack_valid", 32'(nib_valid), 1);
        host_ack = 1'b0;
        tick();
        check("ack_low_valid", 32'(nib_valid), 1);
        host_ack = 1'b1;
        tick();
        check("rearm_gap", 32'(nib_valid), 0);
        host_ack = 1'b0;
        drain();

        // Write-back suppressed when pcpi_wr is low.
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'hFFFFFFFF;
        repeat (3) begin
            tick();
            check("nowr_level", 32'(fifo_level), 0);
            check("nowr_valid", 32'(nib_valid), 0);
        end
        pcpi_ready = 1'b0;
        tick();

        // Full FIFO: write alongside a pop is kept, next write is dropped.
        burst = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        for (int i = 0; i < 4; i++) begin
            pcpi_ready = 1'b1;
            pcpi_wr    = 1'b1;
            pcpi_rd    = burst[i];
            if (i < 3) push_result(burst[i]);
            tick();
            if (i == 2) begin
                check("abc_level", 32'(fifo_level), 2);
                check("abc_no_ovf", 32'(overflow), 0);
            end
        end
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        check("d_drop_ovf", 32'(overflow), 1);
        check("d_drop_level", 32'(fifo_level), 2);
        drain();
        check("abc_level_done", 32'(fifo_level), 0);

        // Drop and clear in the same cycle: set wins; clear alone later.
        burst = '{32'h11110005, 32'h22220006, 32'h33330007, 32'h44440008};
        for (int i = 0; i < 4; i++) begin
            pcpi_ready = 1'b1;
            pcpi_wr    = 1'b1;
            pcpi_rd    = burst[i];
            clear_ovf  = (i == 3);
            if (i < 3) push_result(burst[i]);
            tick();
        end
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        check("set_beats_clear", 32'(overflow), 1);
        tick();
        check("clear_ovf", 32'(overflow), 0);
        clear_ovf = 1'b0;
        drain();

        // Reset mid-stream with one result still buffered.
        capture(32'hFEDC1234);
        capture(32'h0BADF00D);
        repeat (3) begin
            wait_valid();
            ack_pulse();
        end
        check("pre_rst_level", 32'(fifo_level), 1);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("mid_rst_valid", 32'(nib_valid), 0);
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", 32'(nib_valid), 0);
        check("post_rst_busy", 32'(busy), 0);

        // Random traffic kept within FIFO capacity, random host acks.
        for (int c = 0; c < 600; c++) begin
            do_cap     = (exp_q.size() <= NUM_NIB * (FIFO_DEPTH - 1)) && ($urandom_range(0, 3) == 0);
            pcpi_ready = do_cap | ($urandom_range(0, 7) == 0);
            pcpi_wr    = do_cap;
            pcpi_rd    = $urandom;
            if (do_cap) push_result(pcpi_rd);
            host_ack   = 1'($urandom_range(0, 1));
            tick();
        end
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        host_ack   = 1'b0;
        tick();
        drain();
        repeat (3) tick();
        check("rand_ovf", 32'(overflow), 0);
        check("rand_busy", 32'(busy), 0);
        check("rand_level", 32'(fifo_level), 0);
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
